// File: rtl/rv32i_load_store_unit.sv
// rv32i load/store unit: word-aligned accesses to a sync-read data memory,
// sub-word load extraction and read-modify-write for SB/SH stores.
//
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_error                         : response
//   mem_addr/mem_wr_data/mem_wr_ena/mem_rd_data              : memory
//   mem_byte_ena (only with LSU_BYTE_ENABLE_EN)              : write lanes
//
// Optional feature macro: LSU_BYTE_ENABLE_EN. When defined, SB/SH write
// directly with byte enables instead of read-modify-write.
module rv32i_load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    input  logic [31:0] mem_rd_data
`ifdef LSU_BYTE_ENABLE_EN
    ,
    output logic [3:0]  mem_byte_ena
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DATA,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

    state_t      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wr_word_q;
    logic [2:0]  cnt_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;

    logic        req_err;
    logic        bad_f3;
    logic        misal;
    logic [31:0] load_d;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Request legality, evaluated on the live request at accept time.
    always_comb begin
        bad_f3 = 1'b0;
        misal  = 1'b0;
        if (req_we) begin
            bad_f3 = (req_funct3 > 3'd2);
        end else begin
            bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        if (req_funct3[1:0] == 2'b01) begin
            misal = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misal = (req_addr[1:0] != 2'b00);
        end
        req_err = bad_f3 || misal;
    end

    // Load lane selection and extension from the returned word.
    always_comb begin
        lane_b = mem_rd_data[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
        load_d = mem_rd_data;
        case (f3_q[1:0])
            2'b00: begin
                if (f3_q[2]) load_d = {24'h0, lane_b};
                else         load_d = {{24{lane_b[7]}}, lane_b};
            end
            2'b01: begin
                if (f3_q[2]) load_d = {16'h0, lane_h};
                else         load_d = {{16{lane_h[15]}}, lane_h};
            end
            default: load_d = mem_rd_data;
        endcase
    end

`ifdef LSU_BYTE_ENABLE_EN
    logic [3:0] be_q;
`else
    logic [31:0] merge_d;

    // Old word with only the addressed byte/half replaced by store data.
    always_comb begin
        merge_d = mem_rd_data;
        if (f3_q[1:0] == 2'b00) begin
            merge_d[{addr_q[1:0], 3'b000} +: 8] = wr_word_q[7:0];
        end else begin
            merge_d[{addr_q[1], 4'b0000} +: 16] = wr_word_q[15:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= 32'h0;
            wr_word_q    <= 32'h0;
            cnt_q        <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
`ifdef LSU_BYTE_ENABLE_EN
            be_q         <= 4'b0000;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q         <= req_we;
                        f3_q         <= req_funct3;
                        addr_q       <= req_addr;
                        wr_word_q    <= req_wdata;
                        cnt_q        <= 3'd0;
                        resp_rdata_q <= 32'h0;
                        resp_error_q <= 1'b0;
                        if (req_err) begin
                            resp_error_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (!req_we) begin
                            state_q <= S_READ;
                        end else if (req_funct3[1:0] == 2'b10) begin
`ifdef LSU_BYTE_ENABLE_EN
                            be_q    <= 4'b1111;
`endif
                            state_q <= S_WRITE;
                        end else begin
`ifdef LSU_BYTE_ENABLE_EN
                            if (req_funct3[1:0] == 2'b00) begin
                                wr_word_q <= {4{req_wdata[7:0]}};
                                be_q      <= 4'b0001 << req_addr[1:0];
                            end else begin
                                wr_word_q <= {2{req_wdata[15:0]}};
                                be_q      <= 4'b0011 << {req_addr[1], 1'b0};
                            end
                            state_q <= S_WRITE;
`else
                            state_q <= S_READ;
`endif
                        end
                    end
                end
                S_READ: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= 3'd0;
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_DATA: begin
                    if (we_q) begin
`ifndef LSU_BYTE_ENABLE_EN
                        wr_word_q <= merge_d;
`endif
                        state_q <= S_WRITE;
                    end else begin
                        resp_rdata_q <= load_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_error  = resp_error_q;

    // Write strobe is gated by rst so a reset edge never commits a write.
    assign mem_wr_ena  = (state_q == S_WRITE) && rst;

    assign mem_addr    = ((state_q == S_READ) || (state_q == S_DATA) ||
                          (state_q == S_WRITE)) ?
                         {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wr_data = (state_q == S_WRITE) ? wr_word_q : 32'h0;

`ifdef LSU_BYTE_ENABLE_EN
    assign mem_byte_ena = mem_wr_ena ? be_q : 4'b0000;
`endif

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Directed-vector testbench for rv32i_load_store_unit.
// Two instances: READ_LATENCY=1 (main) and READ_LATENCY=3.
module tb_rv32i_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic        resp_valid1;
    logic [31:0] resp_rdata1;
    logic        resp_error1;
    logic [31:0] mem_addr1;
    logic [31:0] mem_wr_data1;
    logic        mem_wr_ena1;
    logic [31:0] mem_rd_data1;
    logic [3:0]  be1;

    logic        req_valid3 = 1'b0;
    logic        req_ready3;
    logic        resp_valid3;
    logic [31:0] resp_rdata3;
    logic        resp_error3;
    logic [31:0] mem_addr3;
    logic [31:0] mem_wr_data3;
    logic        mem_wr_ena3;
    logic [31:0] mem_rd_data3;
    logic [3:0]  be3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

`ifdef LSU_BYTE_ENABLE_EN
    localparam int SUB_LAT = 2;
    localparam int RST_CYC = 1;
    localparam logic [31:0] SB_WDATA = 32'h12121212;
    localparam logic [31:0] SH_WDATA = 32'hCAFECAFE;
`else
    localparam int SUB_LAT = 4;
    localparam int RST_CYC = 2;
    localparam logic [31:0] SB_WDATA = 32'h1299AABB;
    localparam logic [31:0] SH_WDATA = 32'hCAFEBEEF;
`endif

    rv32i_load_store_unit #(.READ_LATENCY(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid1),
        .req_ready   (req_ready1),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid1),
        .resp_rdata  (resp_rdata1),
        .resp_error  (resp_error1),
        .mem_addr    (mem_addr1),
        .mem_wr_data (mem_wr_data1),
        .mem_wr_ena  (mem_wr_ena1),
        .mem_rd_data (mem_rd_data1)
`ifdef LSU_BYTE_ENABLE_EN
        ,
        .mem_byte_ena(be1)
`endif
    );

    rv32i_load_store_unit #(.READ_LATENCY(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid3),
        .req_ready   (req_ready3),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid3),
        .resp_rdata  (resp_rdata3),
        .resp_error  (resp_error3),
        .mem_addr    (mem_addr3),
        .mem_wr_data (mem_wr_data3),
        .mem_wr_ena  (mem_wr_ena3),
        .mem_rd_data (mem_rd_data3)
`ifdef LSU_BYTE_ENABLE_EN
        ,
        .mem_byte_ena(be3)
`endif
    );

`ifndef LSU_BYTE_ENABLE_EN
    assign be1 = 4'hF;
    assign be3 = 4'hF;
`endif

    // Data memory model: 256 words, sync read with per-instance latency.
    logic [31:0] mem [0:255];
    logic [31:0] rd1_q;
    logic [31:0] rd3_q [0:2];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_data = 32'h0;

    always @(posedge clk) begin
        rd1_q    <= mem[mem_addr1[9:2]];
        rd3_q[0] <= mem[mem_addr3[9:2]];
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
        if (pre_we) mem[pre_idx] <= pre_data;
        for (int b = 0; b < 4; b++) begin
            if (mem_wr_ena1 && be1[b])
                mem[mem_addr1[9:2]][b*8 +: 8] <= mem_wr_data1[b*8 +: 8];
            if (mem_wr_ena3 && be3[b])
                mem[mem_addr3[9:2]][b*8 +: 8] <= mem_wr_data3[b*8 +: 8];
        end
    end

    assign mem_rd_data1 = rd1_q;
    assign mem_rd_data3 = rd3_q[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_idx  = a[9:2];
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // One request on the READ_LATENCY=1 instance; called at a negedge in IDLE.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int npulse,
                         output logic [31:0] waddr, output logic [31:0] wdat,
                         output logic [3:0] wbe, output logic [31:0] rdat,
                         output logic err, output logic [31:0] raddr);
        lat    = -1;
        npulse = 0;
        waddr  = 32'h0;
        wdat   = 32'h0;
        wbe    = 4'h0;
        rdat   = 32'h0;
        err    = 1'b0;
        raddr  = 32'h0;
        check("ready_before_req", {31'h0, req_ready1}, 32'h1);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) raddr = mem_addr1;
            if (mem_wr_ena1) begin
                npulse++;
                waddr = mem_addr1;
                wdat  = mem_wr_data1;
                wbe   = be1;
            end
            if (resp_valid1) begin
                lat  = c;
                rdat = resp_rdata1;
                err  = resp_error1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("resp_one_cycle", {31'h0, resp_valid1}, 32'h0);
    endtask

    int          lat;
    int          np;
    int          rv;
    int          held;
    int          busy_rdy;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  wb;
    logic [31:0] rd;
    logic        er;
    logic [31:0] ra;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {31'h0, resp_valid1}, 32'h0);
        check("rst_resp_rdata", resp_rdata1, 32'h0);
        check("rst_resp_error", {31'h0, resp_error1}, 32'h0);
        check("rst_wr_ena", {31'h0, mem_wr_ena1}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'h0, req_ready1}, 32'h1);
        check("idle_mem_addr", mem_addr1, 32'h0);
        check("idle_wr_data", mem_wr_data1, 32'h0);

        preload(32'h100, 32'h8899AABB);
        preload(32'h104, 32'h00000000);
        preload(32'h108, 32'h00000000);

        // READ_LATENCY=3: LW held address, latency, and busy-ignore.
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        req_valid3 = 1'b1;
        @(negedge clk);
        req_addr = 32'h200;
        held     = 0;
        busy_rdy = 0;
        lat      = -1;
        rd       = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_addr3 == 32'h100) held++;
            if (req_ready3) busy_rdy++;
            if (resp_valid3) begin
                lat = c;
                rd  = resp_rdata3;
                break;
            end
            @(negedge clk);
        end
        req_valid3 = 1'b0;
        check("rl3_lat", lat, 32'd5);
        check("rl3_rdata", rd, 32'h8899AABB);
        check("rl3_addr_held", held, 32'd4);
        check("rl3_busy_ready", busy_rdy, 32'd0);
        @(negedge clk);
        check("rl3_ready_after", {31'h0, req_ready3}, 32'h1);
        check("rl3_no_reaccept", mem_addr3, 32'h0);
        @(negedge clk);
        check("rl3_still_idle", mem_addr3, 32'h0);

        // Loads from 0x8899AABB.
        issue(1'b0, 3'b000, 32'h101, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("lb_lat", lat, 32'd3);
        check("lb_rdata", rd, 32'hFFFFFFAA);
        check("lb_err", {31'h0, er}, 32'h0);
        check("lb_no_write", np, 32'd0);
        check("lb_mem_addr", ra, 32'h100);
        issue(1'b0, 3'b101, 32'h102, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("lhu_rdata", rd, 32'h00008899);
        check("lhu_lat", lat, 32'd3);
        issue(1'b0, 3'b001, 32'h102, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("lh_rdata", rd, 32'hFFFF8899);
        issue(1'b0, 3'b100, 32'h100, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("lbu_rdata", rd, 32'h000000BB);
        issue(1'b0, 3'b010, 32'h100, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("lw_rdata", rd, 32'h8899AABB);

        // SB into byte 3.
        issue(1'b1, 3'b000, 32'h103, 32'h12, lat, np, wa, wd, wb, rd, er, ra);
        check("sb_pulses", np, 32'd1);
        check("sb_wr_addr", wa, 32'h100);
        check("sb_wr_data", wd, SB_WDATA);
        check("sb_lat", lat, SUB_LAT);
        check("sb_rdata", rd, 32'h0);
`ifdef LSU_BYTE_ENABLE_EN
        check("sb_byte_ena", {28'h0, wb}, 32'h8);
`endif
        check("sb_mem", mem[64], 32'h1299AABB);
        issue(1'b0, 3'b000, 32'h103, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("lb_after_sb", rd, 32'h00000012);

        // Errors: misaligned SW, illegal funct3, misaligned LH.
        issue(1'b1, 3'b010, 32'h102, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("sw_mis_lat", lat, 32'd1);
        check("sw_mis_err", {31'h0, er}, 32'h1);
        check("sw_mis_rdata", rd, 32'h0);
        check("sw_mis_no_write", np, 32'd0);
        issue(1'b0, 3'b011, 32'h100, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("ld_f3_011_err", {31'h0, er}, 32'h1);
        check("ld_f3_011_lat", lat, 32'd1);
        issue(1'b0, 3'b110, 32'h100, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("ld_f3_110_err", {31'h0, er}, 32'h1);
        issue(1'b1, 3'b100, 32'h100, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("st_f3_100_err", {31'h0, er}, 32'h1);
        check("st_f3_100_no_write", np, 32'd0);
        issue(1'b0, 3'b001, 32'h101, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("lh_mis_err", {31'h0, er}, 32'h1);
        check("lh_mis_rdata", rd, 32'h0);

        // SW then SH into upper half.
        issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, lat, np, wa, wd, wb, rd, er, ra);
        check("sw_lat", lat, 32'd2);
        check("sw_pulses", np, 32'd1);
        check("sw_wr_addr", wa, 32'h104);
        check("sw_wr_data", wd, 32'hDEADBEEF);
        check("sw_err", {31'h0, er}, 32'h0);
`ifdef LSU_BYTE_ENABLE_EN
        check("sw_byte_ena", {28'h0, wb}, 32'hF);
`endif
        issue(1'b1, 3'b001, 32'h106, 32'h1234CAFE, lat, np, wa, wd, wb, rd, er, ra);
        check("sh_lat", lat, SUB_LAT);
        check("sh_wr_data", wd, SH_WDATA);
`ifdef LSU_BYTE_ENABLE_EN
        check("sh_byte_ena", {28'h0, wb}, 32'hC);
`endif
        check("sh_mem", mem[65], 32'hCAFEBEEF);
        issue(1'b0, 3'b001, 32'h106, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("lh_after_sh", rd, 32'hFFFFCAFE);

        // Top-of-address-space word.
        issue(1'b1, 3'b010, 32'hFFFFFFFC, 32'h13579BDF,
              lat, np, wa, wd, wb, rd, er, ra);
        check("wrap_wr_addr", wa, 32'hFFFFFFFC);
        check("wrap_err", {31'h0, er}, 32'h0);
        issue(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, lat, np, wa, wd, wb, rd, er, ra);
        check("wrap_rd_addr", ra, 32'hFFFFFFFC);
        check("wrap_rdata", rd, 32'h13579BDF);

        // Reset during an SH: no write, response dropped, ready at once.
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h100;
        req_wdata  = 32'h5555;
        req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        np = 0;
        rv = 0;
        for (int c = 1; c < RST_CYC; c++) begin
            if (mem_wr_ena1) np++;
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        if (mem_wr_ena1) np++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", {31'h0, req_ready1}, 32'h1);
        check("rst_mid_resp", {31'h0, resp_valid1}, 32'h0);
        repeat (4) begin
            if (mem_wr_ena1) np++;
            if (resp_valid1) rv++;
            @(negedge clk);
        end
        check("rst_mid_no_write", np, 32'd0);
        check("rst_mid_no_resp", rv, 32'd0);
        check("rst_mid_mem", mem[64], 32'h1299AABB);

        // Reset asserted while in WRITE: strobe must drop combinationally.
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h108;
        req_wdata  = 32'h11111111;
        req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_write_ena", {31'h0, mem_wr_ena1}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_write_mem", mem[66], 32'h0);
        check("rst_write_ready", {31'h0, req_ready1}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
